// File: rtl/primogen_pkg.sv
// Shared definitions for the prime sequence generator: FSM encoding and reset values.
package primogen_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StNext,
    StCheck,
    StDiv,
    StTest
  } state_e;

  localparam int unsigned RES_RST   = 1;
  localparam int unsigned COUNT_RST = 0;

endpackage

// File: rtl/primogen_rem.sv
// Restoring remainder unit: one quotient bit per cycle, done pulses WIDTH cycles after start.
module primogen_rem #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] num,
  input  logic [WIDTH-1:0] den,
  output logic             done,
  output logic [WIDTH-1:0] rem
);

  localparam int unsigned CntW = $clog2(WIDTH);

  logic [WIDTH-1:0] rem_q, num_q, den_q;
  logic [CntW-1:0]  cnt_q;
  logic             busy_q, done_q;

  logic [WIDTH-1:0] rem_in, den_in, rem_step;
  logic             bit_in;
  logic [WIDTH:0]   shifted, diff;

  // The start cycle already consumes the MSB so the whole division spans WIDTH edges.
  always_comb begin
    rem_in   = start ? '0 : rem_q;
    den_in   = start ? den : den_q;
    bit_in   = start ? num[WIDTH-1] : num_q[WIDTH-1];
    shifted  = {rem_in, bit_in};
    diff     = shifted - {1'b0, den_in};
    rem_step = (shifted >= {1'b0, den_in}) ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      num_q  <= '0;
      den_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        rem_q  <= rem_step;
        num_q  <= num << 1;
        den_q  <= den;
        cnt_q  <= CntW'(WIDTH - 1);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        rem_q <= rem_step;
        num_q <= num_q << 1;
        cnt_q <= cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done = done_q;
  assign rem  = rem_q;

endmodule

// File: rtl/primogen_seq.sv
// Prime sequence generator: each go searches for the next prime above res by trial division.
module primogen_seq
  import primogen_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic             ready,
  output logic             error,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] count
);

  // Wide enough that sq never wraps while d stays below the square root of cand.
  localparam int unsigned SqW = 2 * WIDTH + 2;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cand_q, cand_d, d_q, d_d, res_q, res_d, count_q, count_d;
  logic [SqW-1:0]   sq_q, sq_d;
  logic             error_q, error_d;

  logic             start, rem_done, sq_gt;
  logic [WIDTH-1:0] rem_val;

  primogen_rem #(
    .WIDTH(WIDTH)
  ) u_rem (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .num  (cand_q),
    .den  (d_q),
    .done (rem_done),
    .rem  (rem_val)
  );

  assign sq_gt = sq_q > SqW'(cand_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cand_q  <= '0;
      d_q     <= '0;
      sq_q    <= '0;
      res_q   <= WIDTH'(RES_RST);
      count_q <= WIDTH'(COUNT_RST);
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      d_q     <= d_d;
      sq_q    <= sq_d;
      res_q   <= res_d;
      count_q <= count_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    d_d     = d_q;
    sq_d    = sq_q;
    res_d   = res_q;
    count_d = count_q;
    error_d = error_q;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          res_d   = seed;
          count_d = WIDTH'(COUNT_RST);
          error_d = 1'b0;
        end else if (go && !error_q) begin
          cand_d  = res_q;
          state_d = StNext;
        end
      end
      StNext: begin
        if (&cand_q) begin
          error_d = 1'b1;
          state_d = StIdle;
        end else begin
          // Seed 0 would otherwise reach 1, which the square test would accept as prime.
          cand_d  = (cand_q == '0) ? WIDTH'(2) : cand_q + WIDTH'(1);
          d_d     = WIDTH'(2);
          sq_d    = SqW'(4);
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (sq_gt) begin
          res_d   = cand_q;
          count_d = count_q + WIDTH'(1);
          state_d = StIdle;
        end else begin
          state_d = StDiv;
        end
      end
      StDiv: begin
        if (rem_done) state_d = StTest;
      end
      StTest: begin
        if (rem_val == '0) begin
          state_d = StNext;
        end else if (d_q == WIDTH'(2)) begin
          d_d     = WIDTH'(3);
          sq_d    = SqW'(9);
          state_d = StCheck;
        end else begin
          // (d+2)^2 = d^2 + 4d + 4
          sq_d    = sq_q + SqW'({d_q, 2'b00}) + SqW'(4);
          d_d     = d_q + WIDTH'(2);
          state_d = StCheck;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ready = (state_q == StIdle);
    start = (state_q == StCheck) && !sq_gt;
  end

  assign error = error_q;
  assign res   = res_q;
  assign count = count_q;

endmodule

// File: tb/tb_primogen_seq.sv
// Randomized self-checking bench for primogen_seq against a sieve-based reference model.
module tb_primogen_seq;

  localparam int Lim = 20000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst8, go8, load8, ready8, error8;
  logic [7:0] seed8, res8, count8;
  logic        rst16, go16, load16, ready16, error16;
  logic [15:0] seed16, res16, count16;

  primogen_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .go(go8), .load(load8), .seed(seed8),
    .ready(ready8), .error(error8), .res(res8), .count(count8)
  );

  primogen_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst16), .go(go16), .load(load16), .seed(seed16),
    .ready(ready16), .error(error16), .res(res16), .count(count16)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit sieve [0:65535];

  task automatic build_sieve();
    for (int i = 0; i < 65536; i++) sieve[i] = (i >= 2);
    for (int i = 2; i * i < 65536; i++)
      if (sieve[i]) for (int j = i * i; j < 65536; j += i) sieve[j] = 1'b0;
  endtask

  // Smallest prime above r that fits, or -1.
  function automatic int ref_next(int r, int maxv);
    for (int c = r + 1; c <= maxv; c++) if (sieve[c]) return c;
    return -1;
  endfunction

  // Cycles from the accepting edge to ready: one per candidate step, WIDTH+2 per divisor trial,
  // one for the final square test.
  function automatic int ref_lat(int r, int w);
    int maxv, lat, prev, c, d, trials;
    bit comp;
    maxv = (1 << w) - 1;
    lat  = 1;
    prev = r;
    while (1) begin
      lat++;
      if (prev == maxv) return lat;
      c      = (prev == 0) ? 2 : prev + 1;
      trials = 0;
      d      = 2;
      comp   = 1'b0;
      while (d * d <= c && !comp) begin
        trials++;
        if (c % d == 0) comp = 1'b1;
        d = (d == 2) ? 3 : d + 2;
      end
      lat += trials * (w + 2);
      if (!comp) return lat + 1;
      prev = c;
    end
    return lat;
  endfunction

  task automatic go8_wait(output int lat);
    go8 = 1'b1; @(posedge clk); #1; go8 = 1'b0; lat = 1;
    while (!ready8 && lat < Lim) begin @(posedge clk); #1; lat++; end
    n_tests++;
    if (ready8 !== 1'b1) begin
      n_fail++; $display("FAIL go8_timeout: ready=%0b after %0d cycles, expected 1", ready8, lat);
    end
  endtask

  task automatic go16_wait(output int lat);
    go16 = 1'b1; @(posedge clk); #1; go16 = 1'b0; lat = 1;
    while (!ready16 && lat < Lim) begin @(posedge clk); #1; lat++; end
    n_tests++;
    if (ready16 !== 1'b1) begin
      n_fail++; $display("FAIL go16_timeout: ready=%0b after %0d cycles, expected 1", ready16, lat);
    end
  endtask

  task automatic load8_seed(input int s);
    seed8 = 8'(s); load8 = 1'b1; @(posedge clk); #1; load8 = 1'b0;
  endtask

  task automatic load16_seed(input int s);
    seed16 = 16'(s); load16 = 1'b1; @(posedge clk); #1; load16 = 1'b0;
  endtask

  task automatic test_reset();
    rst8 = 1'b1; rst16 = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst8 = 1'b0; rst16 = 1'b0;
    n_tests++;
    if ({ready8, error8, res8, count8} !== {1'b1, 1'b0, 8'd1, 8'd0}) begin
      n_fail++; $display("FAIL reset8: ready=%0b error=%0b res=%0d count=%0d, expected 1 0 1 0",
                         ready8, error8, res8, count8);
    end
    n_tests++;
    if ({ready16, error16, res16, count16} !== {1'b1, 1'b0, 16'd1, 16'd0}) begin
      n_fail++; $display("FAIL reset16: ready=%0b error=%0b res=%0d count=%0d, expected 1 0 1 0",
                         ready16, error16, res16, count16);
    end
  endtask

  task automatic test_seq8();
    int r, exp, explat, lat;
    r = 1;
    for (int i = 0; i < 6; i++) begin
      exp = ref_next(r, 255); explat = ref_lat(r, 8);
      go8_wait(lat);
      n_tests++;
      if (res8 !== 8'(exp) || count8 !== 8'(i + 1) || error8 !== 1'b0) begin
        n_fail++; $display("FAIL seq8[%0d]: res=%0d count=%0d error=%0b, expected %0d %0d 0",
                           i, res8, count8, error8, exp, i + 1);
      end
      n_tests++;
      if (lat != explat) begin
        n_fail++; $display("FAIL seq8_lat[%0d]: got %0d cycles, expected %0d", i, lat, explat);
      end
      r = exp;
    end
  endtask

  task automatic test_load_err8();
    int lat;
    load8_seed(250);
    n_tests++;
    if (res8 !== 8'd250 || count8 !== 8'd0 || ready8 !== 1'b1) begin
      n_fail++; $display("FAIL load250: res=%0d count=%0d ready=%0b, expected 250 0 1",
                         res8, count8, ready8);
    end
    go8_wait(lat);
    n_tests++;
    if (res8 !== 8'd251 || count8 !== 8'd1 || error8 !== 1'b0) begin
      n_fail++; $display("FAIL next251: res=%0d count=%0d error=%0b, expected 251 1 0",
                         res8, count8, error8);
    end
    go8_wait(lat);
    n_tests++;
    if (error8 !== 1'b1 || res8 !== 8'd251 || count8 !== 8'd1 || lat != ref_lat(251, 8)) begin
      n_fail++; $display("FAIL overflow8: error=%0b res=%0d count=%0d lat=%0d, expected 1 251 1 %0d",
                         error8, res8, count8, lat, ref_lat(251, 8));
    end
    go8_wait(lat);
    n_tests++;
    if (lat != 1 || error8 !== 1'b1 || res8 !== 8'd251 || count8 !== 8'd1) begin
      n_fail++; $display("FAIL ignored_go8: lat=%0d error=%0b res=%0d count=%0d, expected 1 1 251 1",
                         lat, error8, res8, count8);
    end
    load8_seed(255);
    n_tests++;
    if (error8 !== 1'b0 || res8 !== 8'd255) begin
      n_fail++; $display("FAIL load255: error=%0b res=%0d, expected 0 255", error8, res8);
    end
    go8_wait(lat);
    n_tests++;
    if (error8 !== 1'b1 || res8 !== 8'd255 || lat != 2) begin
      n_fail++; $display("FAIL err_lat8: error=%0b res=%0d lat=%0d, expected 1 255 2",
                         error8, res8, lat);
    end
  endtask

  task automatic test_load_go8();
    int lat;
    seed8 = 8'd89; load8 = 1'b1; go8 = 1'b1;
    @(posedge clk); #1; load8 = 1'b0; go8 = 1'b0;
    n_tests++;
    if (ready8 !== 1'b1 || res8 !== 8'd89 || count8 !== 8'd0 || error8 !== 1'b0) begin
      n_fail++; $display("FAIL load_go8: ready=%0b res=%0d count=%0d error=%0b, expected 1 89 0 0",
                         ready8, res8, count8, error8);
    end
    go8_wait(lat);
    n_tests++;
    if (res8 !== 8'd97 || count8 !== 8'd1) begin
      n_fail++; $display("FAIL after89: res=%0d count=%0d, expected 97 1", res8, count8);
    end
  endtask

  task automatic test_busy8();
    int s, exp, lat;
    for (int k = 0; k < 3; k++) begin
      s = $urandom_range(0, 200);
      exp = ref_next(s, 255);
      load8_seed(s);
      go8 = 1'b1; @(posedge clk); #1; lat = 1;
      while (!ready8 && lat < Lim) begin
        go8 = 1'($urandom_range(0, 1)); load8 = 1'($urandom_range(0, 1)); seed8 = 8'($urandom);
        @(posedge clk); #1; lat++;
      end
      go8 = 1'b0; load8 = 1'b0;
      n_tests++;
      if (ready8 !== 1'b1 || res8 !== 8'(exp) || count8 !== 8'd1) begin
        n_fail++; $display("FAIL busy8[%0d] seed %0d: ready=%0b res=%0d count=%0d, expected 1 %0d 1",
                           k, s, ready8, res8, count8, exp);
      end
    end
  endtask

  task automatic test_edge8();
    int s, exp, lat;
    for (int k = 0; k < 6; k++) begin
      s = $urandom_range(220, 255);
      exp = ref_next(s, 255);
      load8_seed(s);
      go8_wait(lat);
      n_tests++;
      if (exp < 0) begin
        if (error8 !== 1'b1 || res8 !== 8'(s) || count8 !== 8'd0 || lat != ref_lat(s, 8)) begin
          n_fail++; $display("FAIL edge8_err seed %0d: error=%0b res=%0d count=%0d lat=%0d, expected 1 %0d 0 %0d",
                             s, error8, res8, count8, lat, s, ref_lat(s, 8));
        end
      end else if (error8 !== 1'b0 || res8 !== 8'(exp) || lat != ref_lat(s, 8)) begin
        n_fail++; $display("FAIL edge8 seed %0d: error=%0b res=%0d lat=%0d, expected 0 %0d %0d",
                           s, error8, res8, lat, exp, ref_lat(s, 8));
      end
    end
  endtask

  task automatic test_run16();
    int r, exp, lat;
    rst16 = 1'b1; @(posedge clk); #1; rst16 = 1'b0;
    r = 1;
    for (int i = 1; i <= 100; i++) begin
      exp = ref_next(r, 65535);
      go16_wait(lat);
      n_tests++;
      if (res16 !== 16'(exp) || count16 !== 16'(i) || lat != ref_lat(r, 16)) begin
        n_fail++; $display("FAIL run16[%0d]: res=%0d count=%0d lat=%0d, expected %0d %0d %0d",
                           i, res16, count16, lat, exp, i, ref_lat(r, 16));
      end
      r = exp;
    end
  endtask

  task automatic test_rand16();
    int s, exp, lat;
    for (int k = 0; k < 6; k++) begin
      s = $urandom_range(0, 4000);
      exp = ref_next(s, 65535);
      load16_seed(s);
      go16_wait(lat);
      n_tests++;
      if (res16 !== 16'(exp) || count16 !== 16'd1 || lat != ref_lat(s, 16)) begin
        n_fail++; $display("FAIL rand16 seed %0d: res=%0d count=%0d lat=%0d, expected %0d 1 %0d",
                           s, res16, count16, lat, exp, ref_lat(s, 16));
      end
    end
  endtask

  task automatic test_reset_mid16();
    int lat;
    load16_seed(113);
    go16 = 1'b1; @(posedge clk); #1; go16 = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    n_tests++;
    if (ready16 !== 1'b0) begin
      n_fail++; $display("FAIL mid16_busy: ready=%0b, expected 0", ready16);
    end
    rst16 = 1'b1; @(posedge clk); #1; rst16 = 1'b0;
    n_tests++;
    if ({ready16, error16, res16, count16} !== {1'b1, 1'b0, 16'd1, 16'd0}) begin
      n_fail++; $display("FAIL mid16_reset: ready=%0b error=%0b res=%0d count=%0d, expected 1 0 1 0",
                         ready16, error16, res16, count16);
    end
    go16_wait(lat);
    n_tests++;
    if (res16 !== 16'd2 || count16 !== 16'd1 || lat != 3) begin
      n_fail++; $display("FAIL mid16_after: res=%0d count=%0d lat=%0d, expected 2 1 3",
                         res16, count16, lat);
    end
  endtask

  initial begin
    rst8 = 1'b1; go8 = 1'b0; load8 = 1'b0; seed8 = '0;
    rst16 = 1'b1; go16 = 1'b0; load16 = 1'b0; seed16 = '0;
    build_sieve();
    #1;
    test_reset();
    test_seq8();
    test_load_err8();
    test_load_go8();
    test_busy8();
    test_edge8();
    test_run16();
    test_rand16();
    test_reset_mid16();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
